riscv_data_ram: RTL and testbench

Data-side memory responder for the RISC-V core. Sits at the far end of the data bus interface driven by the memory stage, as the target of `data_bif_*`. Accepts one load or store request at a time and applies lane-justified byte masks against a word-organised SRAM. Returns right-justified read data with a single-cycle `ack` pulse after a configurable number of wait states.

---
 rtl/riscv_data_ram_pkg.sv | 23 ++
 rtl/riscv_sram_1rw.sv | 36 +++
 rtl/riscv_data_ram.sv | 138 +++++++++++++
 tb/tb_riscv_data_ram.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_data_ram_pkg.sv
// Shared definitions for the data-side memory responder: FSM state
// encodings, write-mask encodings and the alignment predicate.
package riscv_data_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WMASK_BYTE = 4'b0001;
  localparam logic [3:0] WMASK_HALF = 4'b0011;
  localparam logic [3:0] WMASK_WORD = 4'b1111;

  // A half that would straddle the word boundary, or a word not on a word
  // boundary, cannot be written without losing lanes.
  function automatic logic is_misaligned(input logic [3:0] wmask,
                                         input logic [1:0] off);
    return ((wmask == WMASK_HALF) && (off == 2'd3)) ||
           ((wmask == WMASK_WORD) && (off != 2'd0));
  endfunction

endpackage

// File: rtl/riscv_sram_1rw.sv
// Single-port synchronous SRAM, 32-bit words, byte write enables and a
// registered read port. The read register only updates on read cycles.
// This is the technology-swap point for a hard macro.
module riscv_sram_1rw
  import riscv_data_ram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_wr,
  input  logic [3:0]            i_be,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [31:0] r_q;

  // One access per enabled cycle: byte-masked write or full-word read.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_q <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/riscv_data_ram.sv
// Data-side memory responder for the RISC-V core (target of data_bif_*).
// One request at a time; ack is a registered one-cycle pulse WAIT_CYCLES+1
// cycles after acceptance. The SRAM is accessed in the RESP cycle from the
// latched request only.
// Optional: define RISCV_DATA_RAM_ALIGN_CHECK_EN to drop misaligned writes
// and raise the sticky data_bif_err flag.
module riscv_data_ram
  import riscv_data_ram_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] data_bif_addr,
  input  logic        data_bif_rnw,
  input  logic        data_bif_rdy,
  output logic        data_bif_ack,
  output logic [31:0] data_bif_rdata,
  input  logic [31:0] data_bif_wdata,
  input  logic [3:0]  data_bif_wmask,
  output logic        data_bif_err
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_ack;
  logic                  r_rd_vld;
  logic [1:0]            r_rd_off;
  logic [DEPTH_LOG2+1:0] r_addr;
  logic                  r_rnw;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wmask;
  logic                  w_accept;
  logic                  w_access;
  logic                  w_drop;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_sh;
  logic [31:0]           w_q;
  logic                  w_unused_addr;

  // Upper address bits are ignored: the memory aliases.
  assign w_unused_addr = ^data_bif_addr[31:DEPTH_LOG2+2];

  assign w_accept = (r_state == ST_IDLE) && data_bif_rdy;
  assign w_access = (r_state == ST_RESP);
  assign w_off    = r_addr[1:0];

  // Lane shifters: lanes pushed past bit 31 fall off the 4-bit / 32-bit result.
  assign w_be       = r_wmask << w_off;
  assign w_wdata_sh = r_wdata << {w_off, 3'b000};

`ifdef RISCV_DATA_RAM_ALIGN_CHECK_EN
  logic r_err;

  assign w_drop = !r_rnw && is_misaligned(r_wmask, w_off);

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  r_err <= 1'b0;
    else if (w_access && w_drop) r_err <= 1'b1;
  end

  assign data_bif_err = r_err;
`else
  assign w_drop       = 1'b0;
  assign data_bif_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (data_bif_rdy) w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Wait-state counter: loaded on acceptance, counts down in WAIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                      r_cnt <= 4'd0;
    else if (w_accept)                              r_cnt <= CNT_INIT;
    else if (r_state == ST_WAIT && r_cnt != 4'd0)   r_cnt <= r_cnt - 4'd1;
  end

  // Request registers: captured once at acceptance, the sole access source.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= data_bif_addr[DEPTH_LOG2+1:0];
      r_rnw   <= data_bif_rnw;
      r_wdata <= data_bif_wdata;
      r_wmask <= data_bif_wmask;
    end
  end

  // Ack pulse follows the RESP cycle; read offset tracks the last completed read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ack    <= 1'b0;
      r_rd_vld <= 1'b0;
      r_rd_off <= 2'd0;
    end else begin
      r_ack <= w_access;
      if (w_access && r_rnw) begin
        r_rd_vld <= 1'b1;
        r_rd_off <= w_off;
      end
    end
  end

  riscv_sram_1rw #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_access),
    .i_wr    (!r_rnw && !w_drop),
    .i_be    (w_be),
    .i_addr  (r_addr[DEPTH_LOG2+1:2]),
    .i_wdata (w_wdata_sh),
    .o_rdata (w_q)
  );

  assign data_bif_ack   = r_ack;
  assign data_bif_rdata = r_rd_vld ? (w_q >> {r_rd_off, 3'b000}) : 32'd0;

endmodule

// File: tb/tb_riscv_data_ram.sv
module tb_riscv_data_ram;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] addr;
  logic        rnw;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        rdy0, rdy3;
  logic        ack0, ack3;
  logic [31:0] rdata0, rdata3;
  logic        err0, err3;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl[16];

  always #5 clk = ~clk;

  riscv_data_ram #(.DEPTH_LOG2(4), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .data_bif_addr(addr), .data_bif_rnw(rnw),
    .data_bif_rdy(rdy0), .data_bif_ack(ack0), .data_bif_rdata(rdata0),
    .data_bif_wdata(wdata), .data_bif_wmask(wmask), .data_bif_err(err0));

  riscv_data_ram #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .data_bif_addr(addr), .data_bif_rnw(rnw),
    .data_bif_rdy(rdy3), .data_bif_ack(ack3), .data_bif_rdata(rdata3),
    .data_bif_wdata(wdata), .data_bif_wmask(wmask), .data_bif_err(err3));

  // Drive one request on DUT sel (0 or 3), scramble inputs after acceptance,
  // hold rdy until ack, return ack latency (-1 if it never came) and rdata.
  task automatic xfer(input int sel, input logic [31:0] a, input logic r,
                      input logic [31:0] wd, input logic [3:0] wm,
                      output logic [31:0] rd, output int lat);
    @(negedge clk);
    addr = a; rnw = r; wdata = wd; wmask = wm;
    if (sel == 0) rdy0 = 1'b1; else rdy3 = 1'b1;
    @(posedge clk);
    #1;
    addr = ~a; rnw = ~r; wdata = ~wd; wmask = ~wm;
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if ((sel == 0 && ack0) || (sel != 0 && ack3)) begin
        lat = i;
        rd  = (sel == 0) ? rdata0 : rdata3;
        break;
      end
    end
    rdy0 = 1'b0;
    rdy3 = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; rdy0 = 1'b0; rdy3 = 1'b0;
    addr = '0; rnw = 1'b0; wdata = '0; wmask = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({ack0, ack3, err0, err3} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 0000", {ack0, ack3, err0, err3});
    end
    n_vec++;
    if (rdata0 !== 32'd0 || rdata3 !== 32'd0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h/%h required 0/0", rdata0, rdata3);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (ack0 !== 1'b0 || ack3 !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ack: got %b%b required 00", ack0, ack3);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd, e;
    int lat;
    xfer(0, 32'h10, 1'b0, 32'hDEADBEEF, 4'b1111, rd, lat);
    n_vec++;
    if (lat !== 1) begin n_err++; $display("FAIL word_wr_lat: got %0d required 1", lat); end
    exp_q.push_back(32'hDEADBEEF);
    xfer(0, 32'h10, 1'b1, 32'h0, 4'b0000, rd, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e || lat !== 1) begin
      n_err++; $display("FAIL word_rd: got %h lat %0d required %h lat 1", rd, lat, e);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd, e;
    int lat;
    xfer(0, 32'h20, 1'b0, 32'h0, 4'b1111, rd, lat);
    xfer(0, 32'h21, 1'b0, 32'h000000AA, 4'b0001, rd, lat);
    exp_q.push_back(32'h0000AA00);
    xfer(0, 32'h20, 1'b1, 32'h0, 4'b0000, rd, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL byte_word: got %h required %h", rd, e); end
    exp_q.push_back(32'h000000AA);
    xfer(0, 32'h21, 1'b1, 32'h0, 4'b0000, rd, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL byte_rd: got %h required %h", rd, e); end
    xfer(0, 32'h22, 1'b0, 32'h00001234, 4'b0011, rd, lat);
    n_vec++;
    if (rd !== 32'h000000AA) begin
      n_err++; $display("FAIL rdata_hold: got %h required 000000aa", rd);
    end
    exp_q.push_back(32'h1234AA00);
    xfer(0, 32'h20, 1'b1, 32'h0, 4'b0000, rd, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL half_word: got %h required %h", rd, e); end
    exp_q.push_back(32'h00000012);
    xfer(0, 32'h23, 1'b1, 32'h0, 4'b0000, rd, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL rd_off3: got %h required %h", rd, e); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, e;
    int lat, extra;
    xfer(3, 32'h44, 1'b0, 32'hCAFEF00D, 4'b1111, rd, lat);
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL wait_lat: got %0d required 4", lat); end
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack3) extra++;
    end
    n_vec++;
    if (extra !== 0) begin n_err++; $display("FAIL wait_extra_ack: got %0d required 0", extra); end
    exp_q.push_back(32'hCAFEF00D);
    xfer(3, 32'h44, 1'b1, 32'h0, 4'b0000, rd, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e || lat !== 4) begin
      n_err++; $display("FAIL wait_rd: got %h lat %0d required %h lat 4", rd, lat, e);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd, e;
    int lat;
    xfer(0, 32'h40, 1'b0, 32'h5A5A0F0F, 4'b1111, rd, lat);
    exp_q.push_back(32'h5A5A0F0F);
    xfer(0, 32'h00, 1'b1, 32'h0, 4'b0000, rd, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL alias: got %h required %h", rd, e); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, e;
    logic        e_err;
    int lat;
`ifdef RISCV_DATA_RAM_ALIGN_CHECK_EN
    e_err = 1'b1;
    e     = 32'h11223344;
`else
    e_err = 1'b0;
    e     = 32'hFFFF3344;
`endif
    xfer(0, 32'h00, 1'b0, 32'h11223344, 4'b1111, rd, lat);
    xfer(0, 32'h02, 1'b0, 32'hFFFFFFFF, 4'b1111, rd, lat);
    n_vec++;
    if (lat !== 1 || err0 !== e_err) begin
      n_err++; $display("FAIL misalign_err: got err %b lat %0d required err %b lat 1", err0, lat, e_err);
    end
    exp_q.push_back(e);
    xfer(0, 32'h00, 1'b1, 32'h0, 4'b0000, rd, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL misalign_mem: got %h required %h", rd, e); end
    xfer(0, 32'h04, 1'b0, 32'h0, 4'b1111, rd, lat);
    n_vec++;
    if (err0 !== e_err) begin n_err++; $display("FAIL err_sticky: got %b required %b", err0, e_err); end
  endtask

  task automatic test_reset_mid_request();
    logic [31:0] rd, e;
    int lat, acks;
    xfer(3, 32'h30, 1'b0, 32'h11111111, 4'b1111, rd, lat);
    @(negedge clk);
    addr = 32'h30; rnw = 1'b0; wdata = 32'h22222222; wmask = 4'b1111; rdy3 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    rdy3 = 1'b0;
    #1;
    n_vec++;
    if ({ack3, err0, err3} !== 3'b000 || rdata3 !== 32'd0 || rdata0 !== 32'd0) begin
      n_err++;
      $display("FAIL midreset_clear: got ack/err %b rdata %h/%h required 000 0/0",
               {ack3, err0, err3}, rdata3, rdata0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack3) acks++;
    end
    n_vec++;
    if (acks !== 0) begin n_err++; $display("FAIL midreset_ack: got %0d required 0", acks); end
    exp_q.push_back(32'h11111111);
    xfer(3, 32'h30, 1'b1, 32'h0, 4'b0000, rd, lat);
    e = exp_q.pop_front();
    n_vec++;
    if (rd !== e) begin n_err++; $display("FAIL midreset_mem: got %h required %h", rd, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, e, wd;
    logic [3:0]  wm;
    logic [1:0]  off;
    logic [3:0]  w;
    int lat, k;
    for (int i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      xfer(0, 32'(i * 4), 1'b0, mdl[i], 4'b1111, rd, lat);
    end
    for (int n = 0; n < 30; n++) begin
      w   = 4'($urandom_range(0, 15));
      off = 2'($urandom_range(0, 3));
      k   = $urandom_range(0, 4);
      wd  = $urandom;
      if (k == 0) begin
        exp_q.push_back(mdl[w] >> (8 * off));
        xfer(0, {26'd0, w, off}, 1'b1, 32'h0, 4'b0000, rd, lat);
        e = exp_q.pop_front();
        n_vec++;
        if (rd !== e || lat !== 1) begin
          n_err++; $display("FAIL b2b_rd%0d: got %h lat %0d required %h lat 1", n, rd, lat, e);
        end
      end else begin
        case (k)
          1: wm = 4'b0000;
          2: wm = 4'b0001;
          3: begin wm = 4'b0011; if (off == 2'd3) off = 2'd2; end
          default: begin wm = 4'b1111; off = 2'd0; end
        endcase
        for (int b = 0; b < 4; b++) begin
          if (b >= off && wm[b - off]) mdl[w][8*b +: 8] = wd[8*(b - off) +: 8];
        end
        xfer(0, {26'd0, w, off}, 1'b0, wd, wm, rd, lat);
        n_vec++;
        if (lat !== 1) begin n_err++; $display("FAIL b2b_wr%0d: got lat %0d required 1", n, lat); end
      end
    end
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(mdl[i]);
      xfer(0, 32'(i * 4), 1'b1, 32'h0, 4'b0000, rd, lat);
      e = exp_q.pop_front();
      n_vec++;
      if (rd !== e) begin n_err++; $display("FAIL b2b_final%0d: got %h required %h", i, rd, e); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_wait_states();
    test_alias();
    test_misaligned();
    test_reset_mid_request();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
